// File: rtl/decode_execute_register_pkg.sv
// -----------------------------------------------------------------------------
// decode_execute_register_pkg
// Shared pipeline types for the decode -> execute boundary:
//   register_e       architectural integer register index (x0..x31)
//   dx_payload_t     every field held in the decode/execute pipeline register
//   DX_BUBBLE        the single "no instruction" value of that register
//   sat_inc16        saturating increment used by the load-use bubble counter
// No ports (package).
// -----------------------------------------------------------------------------
package decode_execute_register_pkg;

   localparam int unsigned DX_XLEN = 32;

   typedef enum logic [4:0] {
      X0  = 5'd0,  X1  = 5'd1,  X2  = 5'd2,  X3  = 5'd3,
      X4  = 5'd4,  X5  = 5'd5,  X6  = 5'd6,  X7  = 5'd7,
      X8  = 5'd8,  X9  = 5'd9,  X10 = 5'd10, X11 = 5'd11,
      X12 = 5'd12, X13 = 5'd13, X14 = 5'd14, X15 = 5'd15,
      X16 = 5'd16, X17 = 5'd17, X18 = 5'd18, X19 = 5'd19,
      X20 = 5'd20, X21 = 5'd21, X22 = 5'd22, X23 = 5'd23,
      X24 = 5'd24, X25 = 5'd25, X26 = 5'd26, X27 = 5'd27,
      X28 = 5'd28, X29 = 5'd29, X30 = 5'd30, X31 = 5'd31
   } register_e;

   typedef logic [DX_XLEN-1:0] dx_word_t;

   typedef struct packed {
      logic      valid;
      register_e rs1_address;
      register_e rs2_address;
      logic      rd_address_valid;
      register_e rd_address;
      logic      is_load;
      dx_word_t  rs1_data;
      dx_word_t  rs2_data;
      dx_word_t  immediate;
      dx_word_t  pc;
   } dx_payload_t;

   // One bubble encoding shared by reset, flush and load-use insertion.
   localparam dx_payload_t DX_BUBBLE = '{
      valid:            1'b0,
      rs1_address:      X0,
      rs2_address:      X0,
      rd_address_valid: 1'b0,
      rd_address:       X0,
      is_load:          1'b0,
      rs1_data:         {DX_XLEN{1'b0}},
      rs2_data:         {DX_XLEN{1'b0}},
      immediate:        {DX_XLEN{1'b0}},
      pc:               {DX_XLEN{1'b0}}
   };

   localparam logic [15:0] LOAD_USE_COUNT_MAX = 16'hFFFF;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == LOAD_USE_COUNT_MAX) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/decode_execute_register_if.sv
// -----------------------------------------------------------------------------
// decode_execute_register_if
// Bundles the decode-side inputs, execute-side controls and the registered
// decode/execute outputs of the pipeline register.
//   master : decode/execute environment (drives d_*, x_stall_i, flush_i)
//   slave  : the pipeline register (drives d_stall_o, dx_*, load_use_count_o)
// Parameter XLEN: data / PC / immediate width.
// -----------------------------------------------------------------------------
interface decode_execute_register_if
   import decode_execute_register_pkg::*;
#(
   parameter int unsigned XLEN = DX_XLEN
);

   // decode stage
   logic            d_valid_i;
   register_e       d_rs1_address_i;
   register_e       d_rs2_address_i;
   logic            d_rs1_used_i;
   logic            d_rs2_used_i;
   logic            d_rd_address_valid_i;
   register_e       d_rd_address_i;
   logic            d_is_load_i;
   logic [XLEN-1:0] d_rs1_data_i;
   logic [XLEN-1:0] d_rs2_data_i;
   logic [XLEN-1:0] d_immediate_i;
   logic [XLEN-1:0] d_pc_i;

   // execute stage control
   logic            x_stall_i;
   logic            flush_i;

   // back-pressure to decode/fetch
   logic            d_stall_o;

   // registered decode/execute copies
   logic            dx_valid_o;
   register_e       dx_rs1_address_o;
   register_e       dx_rs2_address_o;
   logic            dx_rd_address_valid_o;
   register_e       dx_rd_address_o;
   logic            dx_is_load_o;
   logic [XLEN-1:0] dx_rs1_data_o;
   logic [XLEN-1:0] dx_rs2_data_o;
   logic [XLEN-1:0] dx_immediate_o;
   logic [XLEN-1:0] dx_pc_o;
   logic [15:0]     load_use_count_o;

   modport master (
      output d_valid_i, d_rs1_address_i, d_rs2_address_i, d_rs1_used_i,
             d_rs2_used_i, d_rd_address_valid_i, d_rd_address_i, d_is_load_i,
             d_rs1_data_i, d_rs2_data_i, d_immediate_i, d_pc_i,
             x_stall_i, flush_i,
      input  d_stall_o, dx_valid_o, dx_rs1_address_o, dx_rs2_address_o,
             dx_rd_address_valid_o, dx_rd_address_o, dx_is_load_o,
             dx_rs1_data_o, dx_rs2_data_o, dx_immediate_o, dx_pc_o,
             load_use_count_o
   );

   modport slave (
      input  d_valid_i, d_rs1_address_i, d_rs2_address_i, d_rs1_used_i,
             d_rs2_used_i, d_rd_address_valid_i, d_rd_address_i, d_is_load_i,
             d_rs1_data_i, d_rs2_data_i, d_immediate_i, d_pc_i,
             x_stall_i, flush_i,
      output d_stall_o, dx_valid_o, dx_rs1_address_o, dx_rs2_address_o,
             dx_rd_address_valid_o, dx_rd_address_o, dx_is_load_o,
             dx_rs1_data_o, dx_rs2_data_o, dx_immediate_o, dx_pc_o,
             load_use_count_o
   );

endinterface

// File: rtl/decode_execute_register_load_use_detector.sv
// -----------------------------------------------------------------------------
// load_use_detector
// Purely combinational load-use hazard check between the instruction held in
// the decode/execute register and the instruction currently in decode.
// Ports:
//   dx_valid, dx_is_load, dx_rd_address_valid, dx_rd_address : older stage
//   d_valid, d_rs1_used, d_rs1_address, d_rs2_used, d_rs2_address : decode
//   hazard : decode must wait one cycle for the load result
// -----------------------------------------------------------------------------
module load_use_detector
   import decode_execute_register_pkg::*;
(
   input  logic      dx_valid,
   input  logic      dx_is_load,
   input  logic      dx_rd_address_valid,
   input  register_e dx_rd_address,
   input  logic      d_valid,
   input  logic      d_rs1_used,
   input  register_e d_rs1_address,
   input  logic      d_rs2_used,
   input  register_e d_rs2_address,
   output logic      hazard
);

   logic producer_s;
   logic rs1_match_s;
   logic rs2_match_s;

   // A load writing x0 produces nothing observable, so it never blocks.
   always_comb begin
      producer_s  = dx_valid & dx_is_load & dx_rd_address_valid
                    & (dx_rd_address != X0);
      rs1_match_s = d_rs1_used & (d_rs1_address == dx_rd_address);
      rs2_match_s = d_rs2_used & (d_rs2_address == dx_rd_address);
      if (producer_s && d_valid) begin
         hazard = rs1_match_s | rs2_match_s;
      end else begin
         hazard = 1'b0;
      end
   end

endmodule

// File: rtl/decode_execute_register.sv
// -----------------------------------------------------------------------------
// decode_execute_register
// Decode -> execute pipeline register with flush, execute back-pressure and
// load-use bubble insertion, plus a saturating count of load-use bubbles.
// Ports:
//   clk_i  : sole clock, rising edge
//   rst_ni : asynchronous active-low reset (register -> bubble, count -> 0)
//   bus    : decode_execute_register_if.slave carrying d_* inputs,
//            x_stall_i / flush_i, d_stall_o and all registered dx_* outputs
// Edge priority: flush > execute stall > load-use hazard > capture.
// -----------------------------------------------------------------------------
module decode_execute_register
   import decode_execute_register_pkg::*;
#(
   parameter int unsigned XLEN = DX_XLEN
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   decode_execute_register_if.slave   bus
);

   dx_payload_t payload_r;
   dx_payload_t capture_s;
   dx_payload_t next_payload_s;
   logic [15:0] count_r;
   logic [15:0] next_count_s;
   logic        hazard_s;
   logic        stall_s;

   load_use_detector u_load_use_detector (
      .dx_valid            (payload_r.valid),
      .dx_is_load          (payload_r.is_load),
      .dx_rd_address_valid (payload_r.rd_address_valid),
      .dx_rd_address       (payload_r.rd_address),
      .d_valid             (bus.d_valid_i),
      .d_rs1_used          (bus.d_rs1_used_i),
      .d_rs1_address       (bus.d_rs1_address_i),
      .d_rs2_used          (bus.d_rs2_used_i),
      .d_rs2_address       (bus.d_rs2_address_i),
      .hazard              (hazard_s)
   );

   // Pack the decode fields; an invalid decode slot becomes a clean bubble.
   always_comb begin
      capture_s = DX_BUBBLE;
      if (bus.d_valid_i) begin
         capture_s.valid            = 1'b1;
         capture_s.rs1_address      = bus.d_rs1_address_i;
         capture_s.rs2_address      = bus.d_rs2_address_i;
         capture_s.rd_address_valid = bus.d_rd_address_valid_i;
         capture_s.rd_address       = bus.d_rd_address_i;
         capture_s.is_load          = bus.d_is_load_i;
         capture_s.rs1_data         = DX_XLEN'(bus.d_rs1_data_i);
         capture_s.rs2_data         = DX_XLEN'(bus.d_rs2_data_i);
         capture_s.immediate        = DX_XLEN'(bus.d_immediate_i);
         capture_s.pc               = DX_XLEN'(bus.d_pc_i);
      end else begin
         capture_s = DX_BUBBLE;
      end
   end

   // Prioritised next-state selection; also drives the decode stall.
   always_comb begin
      next_payload_s = payload_r;
      next_count_s   = count_r;
      stall_s        = 1'b0;
      if (bus.flush_i) begin
         // Redirect wins: the squashed decode slot need not be held.
         next_payload_s = DX_BUBBLE;
         stall_s        = 1'b0;
      end else if (bus.x_stall_i) begin
         next_payload_s = payload_r;
         stall_s        = 1'b1;
      end else if (hazard_s) begin
         // Decode keeps the consumer; one bubble lets the load reach MW.
         next_payload_s = DX_BUBBLE;
         next_count_s   = sat_inc16(count_r);
         stall_s        = 1'b1;
      end else begin
         next_payload_s = capture_s;
         stall_s        = 1'b0;
      end
   end

   // Pipeline register and bubble counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         payload_r <= DX_BUBBLE;
         count_r   <= 16'd0;
      end else begin
         payload_r <= next_payload_s;
         count_r   <= next_count_s;
      end
   end

   assign bus.d_stall_o             = stall_s;
   assign bus.dx_valid_o            = payload_r.valid;
   assign bus.dx_rs1_address_o      = payload_r.rs1_address;
   assign bus.dx_rs2_address_o      = payload_r.rs2_address;
   assign bus.dx_rd_address_valid_o = payload_r.rd_address_valid;
   assign bus.dx_rd_address_o       = payload_r.rd_address;
   assign bus.dx_is_load_o          = payload_r.is_load;
   assign bus.dx_rs1_data_o         = XLEN'(payload_r.rs1_data);
   assign bus.dx_rs2_data_o         = XLEN'(payload_r.rs2_data);
   assign bus.dx_immediate_o        = XLEN'(payload_r.immediate);
   assign bus.dx_pc_o               = XLEN'(payload_r.pc);
   assign bus.load_use_count_o      = count_r;

endmodule

// File: tb/tb_decode_execute_register.sv
// -----------------------------------------------------------------------------
// tb_decode_execute_register
// Directed self-checking bench for decode_execute_register. Operand data is
// derived from the PC of each instruction: rs1 = pc+0x1000, rs2 = pc+0x2000,
// imm = pc+0x3000, so expected data values are written out by hand below.
// -----------------------------------------------------------------------------
module tb_decode_execute_register;
   import decode_execute_register_pkg::*;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   decode_execute_register_if #(.XLEN(32)) bus ();

   decode_execute_register #(.XLEN(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input register_e rs1, input logic rs1_used,
                        input register_e rs2, input logic rs2_used,
                        input logic rd_valid, input register_e rd,
                        input logic is_load, input logic [31:0] pc);
      bus.d_valid_i            = valid;
      bus.d_rs1_address_i      = rs1;
      bus.d_rs1_used_i         = rs1_used;
      bus.d_rs2_address_i      = rs2;
      bus.d_rs2_used_i         = rs2_used;
      bus.d_rd_address_valid_i = rd_valid;
      bus.d_rd_address_i       = rd;
      bus.d_is_load_i          = is_load;
      bus.d_pc_i               = pc;
      bus.d_rs1_data_i         = pc + 32'h0000_1000;
      bus.d_rs2_data_i         = pc + 32'h0000_2000;
      bus.d_immediate_i        = pc + 32'h0000_3000;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.x_stall_i = 1'b1;
      bus.flush_i   = 1'b0;
      drive(1'b0, X0, 1'b0, X0, 1'b0, 1'b0, X0, 1'b0, 32'h0);

      // Reset state
      #2;
      check("rst_valid", 32'(bus.dx_valid_o), 32'd0);
      check("rst_count", 32'(bus.load_use_count_o), 32'd0);
      check("rst_stall_xstall", 32'(bus.d_stall_o), 32'd1);
      bus.x_stall_i = 1'b0;
      #1;
      check("rst_stall", 32'(bus.d_stall_o), 32'd0);
      #9;
      rst_n = 1'b1;

      // Load-use on rs1: lw x5 ; add x6,x5,x7
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h40);
      step();
      check("ld_valid", 32'(bus.dx_valid_o), 32'd1);
      check("ld_is_load", 32'(bus.dx_is_load_o), 32'd1);
      check("ld_rd", 32'(bus.dx_rd_address_o), 32'd5);
      check("ld_pc", bus.dx_pc_o, 32'h40);
      check("ld_rs1_data", bus.dx_rs1_data_o, 32'h1040);
      drive(1'b1, X5, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h44);
      #1;
      check("lu_stall", 32'(bus.d_stall_o), 32'd1);
      step();
      check("lu_bubble_valid", 32'(bus.dx_valid_o), 32'd0);
      check("lu_bubble_pc", bus.dx_pc_o, 32'h0);
      check("lu_bubble_rdv", 32'(bus.dx_rd_address_valid_o), 32'd0);
      check("lu_count", 32'(bus.load_use_count_o), 32'd1);
      check("lu_stall_released", 32'(bus.d_stall_o), 32'd0);
      step();
      check("add_valid", 32'(bus.dx_valid_o), 32'd1);
      check("add_pc", bus.dx_pc_o, 32'h44);
      check("add_rs2_data", bus.dx_rs2_data_o, 32'h2044);
      check("add_imm", bus.dx_immediate_o, 32'h3044);
      check("add_rd", 32'(bus.dx_rd_address_o), 32'd6);
      check("add_rs1", 32'(bus.dx_rs1_address_o), 32'd5);
      check("add_is_load", 32'(bus.dx_is_load_o), 32'd0);
      check("add_count", 32'(bus.load_use_count_o), 32'd1);

      // Load to x0 never stalls
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X0, 1'b1, 32'h50);
      step();
      drive(1'b1, X0, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h54);
      #1;
      check("x0_stall", 32'(bus.d_stall_o), 32'd0);
      step();
      check("x0_pc", bus.dx_pc_o, 32'h54);
      check("x0_count", 32'(bus.load_use_count_o), 32'd1);

      // Consumer that does not read rs1 never stalls
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h60);
      step();
      drive(1'b1, X5, 1'b0, X7, 1'b1, 1'b1, X6, 1'b0, 32'h64);
      #1;
      check("unused_stall", 32'(bus.d_stall_o), 32'd0);
      step();
      check("unused_pc", bus.dx_pc_o, 32'h64);

      // Load-use through rs2
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h68);
      step();
      drive(1'b1, X7, 1'b1, X5, 1'b1, 1'b1, X6, 1'b0, 32'h6C);
      #1;
      check("rs2_stall", 32'(bus.d_stall_o), 32'd1);
      step();
      check("rs2_count", 32'(bus.load_use_count_o), 32'd2);
      step();
      check("rs2_pc", bus.dx_pc_o, 32'h6C);

      // Hazard and flush together: flush wins, no count
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h70);
      step();
      drive(1'b1, X5, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h74);
      bus.flush_i = 1'b1;
      #1;
      check("flush_stall", 32'(bus.d_stall_o), 32'd0);
      step();
      bus.flush_i = 1'b0;
      check("flush_valid", 32'(bus.dx_valid_o), 32'd0);
      check("flush_count", 32'(bus.load_use_count_o), 32'd2);
      step();
      check("post_flush_pc", bus.dx_pc_o, 32'h74);

      // Execute stall for three cycles holds pc 0x100
      drive(1'b1, X2, 1'b1, X3, 1'b1, 1'b1, X4, 1'b0, 32'h100);
      step();
      check("xs_pc0", bus.dx_pc_o, 32'h100);
      drive(1'b1, X2, 1'b1, X3, 1'b1, 1'b1, X4, 1'b0, 32'h104);
      bus.x_stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("xs_stall", 32'(bus.d_stall_o), 32'd1);
         step();
         check("xs_hold_pc", bus.dx_pc_o, 32'h100);
         check("xs_hold_rs1", bus.dx_rs1_data_o, 32'h1100);
         check("xs_count", 32'(bus.load_use_count_o), 32'd2);
      end
      bus.x_stall_i = 1'b0;
      #1;
      check("xs_release", 32'(bus.d_stall_o), 32'd0);
      step();
      check("xs_next_pc", bus.dx_pc_o, 32'h104);

      // Execute stall over a load-use pair: stall first, then the bubble
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h110);
      step();
      drive(1'b1, X5, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h114);
      bus.x_stall_i = 1'b1;
      step();
      check("xsl_hold_pc", bus.dx_pc_o, 32'h110);
      check("xsl_count", 32'(bus.load_use_count_o), 32'd2);
      bus.x_stall_i = 1'b0;
      #1;
      check("xsl_hazard", 32'(bus.d_stall_o), 32'd1);
      step();
      check("xsl_bubble", 32'(bus.dx_valid_o), 32'd0);
      check("xsl_count2", 32'(bus.load_use_count_o), 32'd3);
      step();
      check("xsl_pc", bus.dx_pc_o, 32'h114);

      // Invalid decode captures a full bubble
      drive(1'b0, X5, 1'b1, X6, 1'b1, 1'b1, X7, 1'b1, 32'h200);
      step();
      check("inv_valid", 32'(bus.dx_valid_o), 32'd0);
      check("inv_pc", bus.dx_pc_o, 32'h0);
      check("inv_rs1_addr", 32'(bus.dx_rs1_address_o), 32'd0);
      check("inv_rdv", 32'(bus.dx_rd_address_valid_o), 32'd0);
      check("inv_is_load", 32'(bus.dx_is_load_o), 32'd0);
      check("inv_imm", bus.dx_immediate_o, 32'h0);

      // Saturation: preset counter near the top
      force dut.count_r = 16'hFFFE;
      #1;
      release dut.count_r;
      #1;
      check("sat_preset", 32'(bus.load_use_count_o), 32'hFFFE);
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h300);
      step();
      drive(1'b1, X5, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h304);
      step();
      check("sat_reach", 32'(bus.load_use_count_o), 32'hFFFF);
      step();
      check("sat_pc", bus.dx_pc_o, 32'h304);
      drive(1'b1, X1, 1'b1, X0, 1'b0, 1'b1, X5, 1'b1, 32'h310);
      step();
      drive(1'b1, X5, 1'b1, X7, 1'b1, 1'b1, X6, 1'b0, 32'h314);
      #1;
      check("sat_stall", 32'(bus.d_stall_o), 32'd1);
      step();
      check("sat_hold", 32'(bus.load_use_count_o), 32'hFFFF);
      check("sat_bubble", 32'(bus.dx_valid_o), 32'd0);

      // Asynchronous reset in the middle of an execute stall
      drive(1'b1, X2, 1'b1, X3, 1'b1, 1'b1, X4, 1'b0, 32'h400);
      step();
      check("ar_pc_before", bus.dx_pc_o, 32'h400);
      bus.x_stall_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(bus.dx_valid_o), 32'd0);
      check("ar_pc", bus.dx_pc_o, 32'h0);
      check("ar_count", 32'(bus.load_use_count_o), 32'd0);
      check("ar_stall", 32'(bus.d_stall_o), 32'd1);
      step();
      rst_n = 1'b1;
      bus.x_stall_i = 1'b0;
      step();
      check("ar_first_capture", bus.dx_pc_o, 32'h400);
      check("ar_first_valid", 32'(bus.dx_valid_o), 32'd1);
      check("ar_count_after", 32'(bus.load_use_count_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 SHALL expose parameter XLEN, default 32, data/PC/immediate width.
REQ-002 SHALL expose clk_i  input  1  sole clock, all state rising-edge.
REQ-003 SHALL expose rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL expose d_valid_i  input  1  decode holds a valid instruction.
REQ-005 SHALL expose d_rs1_address_i, d_rs2_address_i  input  register_e  decoded source registers.
REQ-006 SHALL expose d_rs1_used_i, d_rs2_used_i  input  1  instruction actually reads rs1/rs2.
REQ-007 SHALL expose d_rd_address_valid_i  input  1, d_rd_address_i  input  register_e  destination.
REQ-008 SHALL expose d_is_load_i  input  1  instruction is a load.
REQ-009 SHALL expose d_rs1_data_i, d_rs2_data_i, d_immediate_i, d_pc_i  input  XLEN  operands.
REQ-010 SHALL expose x_stall_i  input  1  execute cannot accept (multicycle op); flush_i  input  1  execute redirect.
REQ-011 SHALL expose d_stall_o  output  1  decode/fetch must hold.
REQ-012 SHALL expose dx_valid_o, dx_rs1_address_o, dx_rs2_address_o, dx_rd_address_valid_o, dx_rd_address_o, dx_is_load_o, dx_rs1_data_o, dx_rs2_data_o, dx_immediate_o, dx_pc_o  output  registered copies, feeding execute and forwarding logic.
REQ-013 SHALL expose load_use_count_o  output  16  saturating count of load-use bubble cycles.

Function
REQ-014 hazard SHALL be combinational: dx_valid_o & dx_is_load_o & dx_rd_address_valid_o & dx_rd_address_o!=0 & d_valid_i & ((d_rs1_used_i & d_rs1_address_i==dx_rd_address_o) | (d_rs2_used_i & d_rs2_address_i==dx_rd_address_o)).
REQ-015 Per-edge priority SHALL be flush_i > x_stall_i > hazard > capture.
REQ-016 flush_i=1: next cycle register holds a bubble; d_stall_o=0 that cycle regardless of x_stall_i or hazard.
REQ-017 x_stall_i=1 (no flush): all register contents hold; d_stall_o=1.
REQ-018 hazard=1 (no flush/stall): next cycle register holds a bubble; d_stall_o=1; decode contents retained upstream.
REQ-019 Otherwise: register captures all d_* fields with dx_valid_o=d_valid_i; d_stall_o=0.
REQ-020 d_valid_i=0 on capture SHALL load a bubble.
REQ-021 Bubble SHALL mean dx_valid_o=0, dx_rd_address_valid_o=0, dx_is_load_o=0, all address/data/immediate/pc fields 0.
REQ-022 Latency: capture-to-output exactly one cycle; a load-use pair SHALL incur exactly one bubble (consumer then sees load in MW, WB-forwarded).
REQ-023 Loads to x0 SHALL never raise hazard.
REQ-024 load_use_count_o SHALL increment on each edge where REQ-018 applies; SHALL saturate at 16'hFFFF; SHALL hold under flush/stall.
REQ-025 d_stall_o SHALL be purely combinational from current state and inputs, no added latency.

Reset
REQ-026 rst_ni low SHALL immediately force register to bubble and load_use_count_o=0, independent of clk_i.
REQ-027 d_stall_o during reset SHALL be 0 (bubble state implies hazard=0) unless x_stall_i=1.
REQ-028 First edge after rst_ni rises SHALL behave as a normal REQ-015 evaluation.

Structure
REQ-029 register_e SHALL come from the existing register-file header; a dx_payload_t packed struct (all registered fields) SHALL be added to a shared pipeline package/header.
REQ-030 Hazard detection SHALL be a sub-module load_use_detector (combinational, reusable by later stages).
REQ-031 Bubble value SHALL be a single package constant DX_BUBBLE used by reset, flush and hazard paths.

Verification
REQ-032 Load x5 in DX; decode add x6,x5,x7 valid -> d_stall_o=1 one cycle, next cycle dx_valid_o=0, following cycle add captured, counter=1.
REQ-033 Same as REQ-032 but load rd=x0 or d_rs1_used_i=0 -> no stall, add captured next cycle, counter=0.
REQ-034 Hazard and flush_i=1 same cycle -> d_stall_o=0, bubble next cycle, counter unchanged.
REQ-035 x_stall_i=1 for 3 cycles with valid pc=0x100 in DX -> outputs hold 0x100, d_stall_o=1 all 3 cycles, counter unchanged.
REQ-036 Counter preset to 0xFFFE via back-to-back load-use pairs -> reaches 0xFFFF and stays after further hazards.
REQ-037 rst_ni asserted mid-stall between clock edges -> outputs bubble and counter 0 immediately, before next clk_i edge.
